// File: rtl/data_unloader_sync.sv
// -----------------------------------------------------------------------------
// data_unloader_sync
// Purpose: single-clock adapter from the APF bridge read port to a narrow
//          synchronous memory read port. One bridge read fetches N sequential
//          memory words (N = 4/INPUT_WORD_SIZE). It packs them into one 32-bit
//          word and holds that word on bridge_rd_data until the next
//          transaction completes.
// Optional feature: define DATA_UNLOADER_BUSY_OUT_EN to add the 'busy' output.
// Ports:
//   clk_74a              in   sole clock, rising edge
//   reset                in   asynchronous active-high reset
//   bridge_rd            in   one-cycle read request strobe
//   bridge_endian_little in   1 = little-endian packing, 0 = big-endian
//   bridge_addr          in   request byte address ([27:0] used)
//   bridge_rd_data       out  packed 32-bit read result
//   read_en              out  memory read strobe
//   read_addr            out  memory byte address
//   read_data            in   memory return data (8*INPUT_WORD_SIZE bits)
//   busy                 out  high while a transaction is in flight (optional)
// -----------------------------------------------------------------------------
module data_unloader_sync #(
   parameter int unsigned INPUT_WORD_SIZE = 2,
   parameter int unsigned READ_LATENCY    = 1
) (
   input  logic                           clk_74a,
   input  logic                           reset,
   input  logic                           bridge_rd,
   input  logic                           bridge_endian_little,
   input  logic [31:0]                    bridge_addr,
   output logic [31:0]                    bridge_rd_data,
   output logic                           read_en,
   output logic [27:0]                    read_addr,
   input  logic [8*INPUT_WORD_SIZE-1:0]   read_data
`ifdef DATA_UNLOADER_BUSY_OUT_EN
   ,
   output logic                           busy
`endif
);

   localparam int unsigned WW = 8 * INPUT_WORD_SIZE;      // memory word width
   localparam int unsigned N  = 4 / INPUT_WORD_SIZE;      // words per transaction
   localparam int unsigned KW = 2;                        // word counter width
   localparam int unsigned LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam int unsigned AW = 28;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [KW-1:0]   k_q, k_d;
   logic [LW-1:0]   lat_q, lat_d;
   logic [AW-1:0]   base_q, base_d;
   logic            le_q, le_d;
   logic [31:0]     buf_q, buf_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            rd_en_q, rd_en_d;
   logic [AW-1:0]   rd_addr_q, rd_addr_d;
`ifdef DATA_UNLOADER_BUSY_OUT_EN
   logic            busy_q, busy_d;
`endif

   // Upper address bits are outside the memory window and intentionally dropped.
   logic unused_addr_bits;
   assign unused_addr_bits = ^bridge_addr[31:AW];

   // Next-state and output computation.
   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      lat_d     = lat_q;
      base_d    = base_q;
      le_d      = le_q;
      buf_d     = buf_q;
      rdata_d   = rdata_q;
      rd_en_d   = 1'b0;
      rd_addr_d = rd_addr_q;

      case (state_q)
         S_IDLE: begin
            if (bridge_rd) begin
               base_d  = bridge_addr[AW-1:0];
               le_d    = bridge_endian_little;
               k_d     = '0;
               state_d = S_REQ;
            end
         end

         S_REQ: begin
            rd_en_d   = 1'b1;
            rd_addr_d = AW'(base_q + AW'(k_q) * AW'(INPUT_WORD_SIZE));
            lat_d     = '0;
            state_d   = S_WAIT;
         end

         S_WAIT: begin
            // lat_q counts cycles since the read_en cycle; capture on the last one.
            if (lat_q == LW'(READ_LATENCY - 1)) begin
               for (int unsigned i = 0; i < N; i++) begin
                  if (k_q == KW'(i)) begin
                     buf_d[i*WW +: WW] = read_data;
                  end
               end
               if (k_q == KW'(N - 1)) begin
                  state_d = S_DONE;
               end else begin
                  k_d     = KW'(k_q + KW'(1));
                  state_d = S_REQ;
               end
            end else begin
               lat_d = LW'(lat_q + LW'(1));
            end
         end

         S_DONE: begin
            // Big-endian is the little-endian word with its bytes reversed.
            rdata_d = le_q ? buf_q
                           : {buf_q[7:0], buf_q[15:8], buf_q[23:16], buf_q[31:24]};
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

`ifdef DATA_UNLOADER_BUSY_OUT_EN
   assign busy_d = (state_d != S_IDLE);
`endif

   // State and datapath registers.
   always_ff @(posedge clk_74a or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         k_q       <= '0;
         lat_q     <= '0;
         base_q    <= '0;
         le_q      <= 1'b0;
         buf_q     <= '0;
         rdata_q   <= '0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
`ifdef DATA_UNLOADER_BUSY_OUT_EN
         busy_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         lat_q     <= lat_d;
         base_q    <= base_d;
         le_q      <= le_d;
         buf_q     <= buf_d;
         rdata_q   <= rdata_d;
         rd_en_q   <= rd_en_d;
         rd_addr_q <= rd_addr_d;
`ifdef DATA_UNLOADER_BUSY_OUT_EN
         busy_q    <= busy_d;
`endif
      end
   end

   assign bridge_rd_data = rdata_q;
   assign read_en        = rd_en_q;
   assign read_addr      = rd_addr_q;
`ifdef DATA_UNLOADER_BUSY_OUT_EN
   assign busy           = busy_q;
`endif

endmodule

// File: tb/tb_data_unloader_sync.sv
// -----------------------------------------------------------------------------
// tb_data_unloader_sync: scoreboard bench for data_unloader_sync
// (INPUT_WORD_SIZE=2, READ_LATENCY=1). Expected read addresses and packed
// results are queued when a request is driven, then popped when the DUT
// strobes read_en or publishes bridge_rd_data.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_data_unloader_sync;

   logic        clk_74a = 1'b0;
   logic        reset;
   logic        bridge_rd;
   logic        bridge_endian_little;
   logic [31:0] bridge_addr;
   logic [31:0] bridge_rd_data;
   logic        read_en;
   logic [27:0] read_addr;
   logic [15:0] read_data;
`ifdef DATA_UNLOADER_BUSY_OUT_EN
   logic        busy;
`endif

   int n_cmp = 0;
   int n_err = 0;

   logic [15:0] mem [1024];
   logic [27:0] rd_q[$];
   logic [31:0] data_q[$];
   logic [31:0] cur_data;
   logic        prev_en;

   data_unloader_sync #(
      .INPUT_WORD_SIZE (2),
      .READ_LATENCY    (1)
   ) dut (
      .clk_74a              (clk_74a),
      .reset                (reset),
      .bridge_rd            (bridge_rd),
      .bridge_endian_little (bridge_endian_little),
      .bridge_addr          (bridge_addr),
      .bridge_rd_data       (bridge_rd_data),
      .read_en              (read_en),
      .read_addr            (read_addr),
      .read_data            (read_data)
`ifdef DATA_UNLOADER_BUSY_OUT_EN
      ,
      .busy                 (busy)
`endif
   );

   always #5 clk_74a = ~clk_74a;

   // Zero-latency memory model: data follows read_addr, so it is stable at the
   // edge that ends the read_en cycle.
   assign read_data = mem[read_addr[9:0]];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pack(input logic [15:0] w0, input logic [15:0] w1,
                                        input logic le);
      logic [31:0] v;
      v = {w1, w0};
      return le ? v : {v[7:0], v[15:8], v[23:16], v[31:24]};
   endfunction

   // Read-strobe monitor: every strobe must be expected, at the right address,
   // and single-cycle.
   always @(negedge clk_74a) begin
      logic [31:0] exp_a;
      if (!reset && read_en) begin
         if (rd_q.size() != 0) exp_a = 32'(rd_q.pop_front());
         else                  exp_a = 32'hDEAD_BEEF;
         check("rd_addr", 32'(read_addr), exp_a);
         check("rd_pulse", 32'(prev_en), 32'd0);
      end
      prev_en = reset ? 1'b0 : read_en;
   end

   // One transaction; intr != 0 pulses an extra bridge_rd (addr 0x200) so that
   // it is sampled at edge E_intr after the accepted request edge E0.
   task automatic do_req(input logic [31:0] addr, input logic le, input int intr);
      logic [27:0] a0, a1;
      logic [31:0] exp;
      a0 = addr[27:0];
      a1 = 28'(a0 + 28'd2);
      exp = pack(mem[a0[9:0]], mem[a1[9:0]], le);
      rd_q.push_back(a0);
      rd_q.push_back(a1);
      data_q.push_back(exp);
      @(negedge clk_74a);
      bridge_rd = 1'b1; bridge_addr = addr; bridge_endian_little = le;
      @(posedge clk_74a); #1;
      bridge_rd = 1'b0;
`ifdef DATA_UNLOADER_BUSY_OUT_EN
      check("busy_rise", 32'(busy), 32'd1);
`endif
      for (int c = 1; c <= 5; c++) begin
         if (c == intr) begin
            @(negedge clk_74a);
            bridge_rd = 1'b1; bridge_addr = 32'h0000_0200;
         end
         @(posedge clk_74a); #1;
         bridge_rd = 1'b0;
         if (c == 4) check("hold_pre", bridge_rd_data, cur_data);
      end
      check("result", bridge_rd_data, data_q.pop_front());
`ifdef DATA_UNLOADER_BUSY_OUT_EN
      check("busy_fall", 32'(busy), 32'd0);
`endif
      cur_data = exp;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
      mem[10'h00C] = 16'hAABB; mem[10'h00E] = 16'hCCDD;
      mem[10'h124] = 16'hBBAA; mem[10'h126] = 16'hDDCC;
      mem[10'h040] = 16'h1111; mem[10'h042] = 16'h2222;
      cur_data = 32'h0;
      prev_en = 1'b0;
      reset = 1'b1; bridge_rd = 1'b0; bridge_endian_little = 1'b1; bridge_addr = 32'h0;
      repeat (3) @(posedge clk_74a);
      @(negedge clk_74a) reset = 1'b0;

      repeat (10) @(posedge clk_74a);
      #1;
      check("idle_rd_en", 32'(read_en), 32'd0);
      check("idle_data", bridge_rd_data, 32'h0);
      check("idle_rd_addr", 32'(read_addr), 32'd0);

      // Basic little-endian, held afterwards.
      do_req(32'h0000_000C, 1'b1, 0);
      check("ref_le", cur_data, 32'hCCDD_AABB);
      repeat (20) @(posedge clk_74a);
      #1 check("held_20", bridge_rd_data, 32'hCCDD_AABB);

      do_req(32'h0000_0124, 1'b1, 0);
      check("ref_le2", cur_data, 32'hDDCC_BBAA);

      do_req(32'h0000_000C, 1'b0, 0);
      check("ref_be", cur_data, 32'hBBAA_DDCC);

      // Requests while busy / on the DONE edge must be ignored.
      do_req(32'h0000_000C, 1'b1, 2);
      do_req(32'h0000_0124, 1'b0, 5);
      repeat (10) @(posedge clk_74a);
      #1 check("ign_hold", bridge_rd_data, cur_data);

      // Upper address bits ignored; 28-bit address wrap.
      do_req(32'hF000_0040, 1'b1, 0);
      do_req(32'h0FFF_FFFE, 1'b1, 0);

      for (int r = 0; r < 4; r++) begin
         do_req($urandom & 32'hF000_03FF, 1'($urandom), 0);
      end

      // Reset between the two read strobes aborts the transaction.
      rd_q.push_back(28'h00C);
      rd_q.push_back(28'h00E);
      @(negedge clk_74a);
      bridge_rd = 1'b1; bridge_addr = 32'h0000_000C; bridge_endian_little = 1'b1;
      @(posedge clk_74a); #1 bridge_rd = 1'b0;
      @(posedge clk_74a); #1;
      @(posedge clk_74a); #1;
      reset = 1'b1;
      #1;
      rd_q.delete();
      check("rst_rd_en", 32'(read_en), 32'd0);
      check("rst_rd_addr", 32'(read_addr), 32'd0);
      check("rst_data", bridge_rd_data, 32'h0);
      cur_data = 32'h0;
      repeat (2) @(posedge clk_74a);
      @(negedge clk_74a) reset = 1'b0;
      repeat (3) @(posedge clk_74a);
      #1 check("rst_no_partial", bridge_rd_data, 32'h0);
      do_req(32'h0000_0040, 1'b1, 0);
      check("ref_after_rst", cur_data, 32'h2222_1111);

      repeat (5) @(posedge clk_74a);
      #1 check("rd_q_left", 32'(rd_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/data_unloader_sync.md
Name: data_unloader_sync

Overview:
- Single-clock bridge-read adapter between the APF bridge read port and a narrow synchronous memory read port.
- A bridge read request latches the address and issues sequential memory reads of INPUT_WORD_SIZE bytes each.
- The returned words are packed into one 32-bit word, byte-ordered per bridge_endian_little.
- The packed word is presented on bridge_rd_data and held until the next transaction completes.

Parameters:
- INPUT_WORD_SIZE, 2, memory word width in bytes; legal values 1, 2, 4. Word count per transaction N = 4/INPUT_WORD_SIZE.
- READ_LATENCY, 1, cycles from the read_en cycle to read_data capture (1 = captured at the edge that ends the read_en cycle).

Ports:
- clk_74a  input  1  sole clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- bridge_rd  input  1  one-cycle read request strobe.
- bridge_endian_little  input  1  1 = little-endian packing, 0 = big-endian.
- bridge_addr  input  32  byte address of the request; bits [27:0] are used.
- bridge_rd_data  output  32  packed read result.
- read_en  output  1  memory read strobe.
- read_addr  output  28  memory byte address.
- read_data  input  8*INPUT_WORD_SIZE  memory return data.

Behaviour:
- Reset (asynchronous, active-high): bridge_rd_data=0, read_en=0, read_addr=0, FSM=IDLE, word counter=0. Reset mid-transaction aborts it; no partial result is published.
- FSM states: IDLE -> REQ -> WAIT -> (REQ | DONE) -> IDLE.
- IDLE: on an edge with bridge_rd=1, latch bridge_addr[27:0] and bridge_endian_little, clear the counter k, go to REQ. bridge_rd with any other state is ignored; the transaction in flight is unaffected.
- REQ: read_en=1 for exactly one cycle with read_addr = base + k*INPUT_WORD_SIZE (28-bit wrap).
- First read_en is high in the 2nd cycle after the bridge_rd edge.
- WAIT: read_data captured READ_LATENCY cycles after the read_en cycle into slot k.
- read_addr holds its last value while read_en=0.
- One idle cycle separates each capture from the next read_en.
- After N captures go to DONE.
- DONE: for one cycle, update bridge_rd_data; return to IDLE.
- Little-endian packing: word k occupies bits [8*INPUT_WORD_SIZE*(k+1)-1 : 8*INPUT_WORD_SIZE*k].
- Big-endian packing: the little-endian result with its 4 bytes reversed.
- bridge_rd_data changes only in DONE and otherwise holds indefinitely.
- bridge_rd on the same edge that DONE completes is ignored; the FSM is not yet in IDLE.
- No alignment checks; unaligned addresses are passed through unchanged.

Optional Feature:
- Macro DATA_UNLOADER_BUSY_OUT_EN.
- Defined: adds output port busy (1 bit), high in every non-IDLE state, 0 after reset. It rises the cycle after an accepted bridge_rd and falls the cycle after DONE.
- Undefined: no busy port; all other behaviour is identical.

Test Plan:
- Reset then idle for 10 cycles -> read_en=0, bridge_rd_data=0x00000000.
- bridge_rd pulse, addr 0xC, little, read_data 0xAABB then 0xCCDD -> two single-cycle read_en strobes, read_addr 0xC then 0xE; bridge_rd_data=0xCCDDAABB, still held 20 cycles later.
- Second request, addr 0x124, read_data 0xBBAA then 0xDDCC -> read_addr 0x124 then 0x126; bridge_rd_data=0xDDCCBBAA.
- Same as the 0xC case with bridge_endian_little=0 -> bridge_rd_data=0xBBAADDCC.
- bridge_rd pulse while busy with addr 0x200 -> ignored: no read at 0x200, first result intact.
- Reset asserted between the two read_en strobes -> all outputs 0 immediately. A new request to 0x40 completes normally.
